// File: rtl/ald_sim_pkg.sv
// Shared types and default constants for the ALD chamber plant model.
// Default values describe a 1 kHz tick, 1000-unit atmosphere and a 25..200 degree reactor.
package ald_sim_pkg;

  typedef enum logic [1:0] {
    COLD    = 2'd0,
    HEATING = 2'd1,
    AT_TEMP = 2'd2,
    COOLING = 2'd3
  } temp_state_e;

  localparam int DEF_W             = 16;
  localparam int DEF_PRESS_MAX     = 1000;
  localparam int DEF_PUMP_RATE     = 4;
  localparam int DEF_LEAK_RATE     = 1;
  localparam int DEF_FILL_RATE     = 8;
  localparam int DEF_PULSE_ADD     = 2;
  localparam int DEF_PSW_THRESH    = 100;
  localparam int DEF_ATM_THRESH    = 950;
  localparam int DEF_TEMP_AMBIENT  = 25;
  localparam int DEF_TEMP_TARGET   = 200;
  localparam int DEF_HEAT_DIV      = 4;
  localparam int DEF_COOL_DIV      = 8;
  localparam int DEF_P1_WARM_TICKS = 500;

  localparam int DIV_W   = 16;
  localparam int COUNT_W = 16;

endpackage

// File: rtl/ald_pulse_counter.sv
// Counts rising edges of one pulse valve every clk, saturating at all-ones.
module ald_pulse_counter
  import ald_sim_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               valve_i,
  output logic [COUNT_W-1:0] count_o
);

  logic               prev_q;
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (valve_i && !prev_q && (count_q != {COUNT_W{1'b1}}))
      count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= valve_i;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ald_chamber_sim.sv
// Closed-loop ALD reactor plant: turns valve/MFC/heater commands into chamber sensor readings.
// Pressure, temperature and warm-up state advance only on the 1 kHz tick strobe.
module ald_chamber_sim
  import ald_sim_pkg::*;
#(
  parameter int W             = DEF_W,
  parameter int PRESS_MAX     = DEF_PRESS_MAX,
  parameter int PUMP_RATE     = DEF_PUMP_RATE,
  parameter int LEAK_RATE     = DEF_LEAK_RATE,
  parameter int FILL_RATE     = DEF_FILL_RATE,
  parameter int PULSE_ADD     = DEF_PULSE_ADD,
  parameter int PSW_THRESH    = DEF_PSW_THRESH,
  parameter int ATM_THRESH    = DEF_ATM_THRESH,
  parameter int TEMP_AMBIENT  = DEF_TEMP_AMBIENT,
  parameter int TEMP_TARGET   = DEF_TEMP_TARGET,
  parameter int HEAT_DIV      = DEF_HEAT_DIV,
  parameter int COOL_DIV      = DEF_COOL_DIV,
  parameter int P1_WARM_TICKS = DEF_P1_WARM_TICKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         vv1,
  input  logic         vv2,
  input  logic         sv1,
  input  logic         sv4,
  input  logic         mfc,
  input  logic         reactorheater,
  input  logic         heaterson,
  output logic [W-1:0] pressure,
  output logic [W-1:0] temp,
  output logic         pressure_switch,
  output logic         atmosphere,
  output logic         tr,
  output logic         tp1,
  output logic         fault,
  output logic [15:0]  pulses_p1,
  output logic [15:0]  pulses_w,
  output logic [1:0]   temp_state_dbg
);

  localparam int PW = W + 2;

  // ---------------- pressure ----------------
  logic [W-1:0]          pressure_q, pressure_d;
  logic                  psw_q, atm_q, fault_q;
  logic signed [PW-1:0]  delta, p_sum;

  // Signed headroom of two bits lets the sum go below zero or above the ceiling before clamping.
  always_comb begin
    delta = '0;
    if (mfc)          delta = delta + PW'(FILL_RATE);
    if (sv1 || sv4)   delta = delta + PW'(PULSE_ADD);
    if (!(vv1 || vv2)) delta = delta + PW'(LEAK_RATE);
    if (vv1)          delta = delta - PW'(PUMP_RATE);
    if (vv2)          delta = delta - PW'(PUMP_RATE);
    p_sum = $signed({2'b00, pressure_q}) + delta;
    if (p_sum < 0)
      pressure_d = '0;
    else if (p_sum > $signed(PW'(PRESS_MAX)))
      pressure_d = W'(PRESS_MAX);
    else
      pressure_d = p_sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pressure_q <= W'(PRESS_MAX);
      psw_q      <= 1'b0;
      atm_q      <= 1'b1;
      fault_q    <= 1'b0;
    end else if (tick) begin
      pressure_q <= pressure_d;
      psw_q      <= (pressure_d <= W'(PSW_THRESH));
      atm_q      <= (pressure_d >= W'(ATM_THRESH));
      if (sv1 && sv4) fault_q <= 1'b1;
    end
  end

  // ---------------- reactor temperature ----------------
  temp_state_e        state_q;
  logic [W-1:0]       temp_q;
  logic [DIV_W-1:0]   div_q;
  logic               tr_q;

  // A heater change on the same tick as a divider rollover changes state without stepping temp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLD;
      temp_q  <= W'(TEMP_AMBIENT);
      div_q   <= '0;
      tr_q    <= 1'b0;
    end else if (tick) begin
      case (state_q)
        COLD: begin
          if (reactorheater) begin
            state_q <= HEATING;
            div_q   <= '0;
          end
        end
        HEATING: begin
          if (!reactorheater) begin
            state_q <= COOLING;
            div_q   <= '0;
          end else if (div_q == DIV_W'(HEAT_DIV - 1)) begin
            temp_q <= temp_q + W'(1);
            div_q  <= '0;
            if (temp_q >= W'(TEMP_TARGET - 1)) begin
              state_q <= AT_TEMP;
              tr_q    <= 1'b1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        AT_TEMP: begin
          if (!reactorheater) begin
            state_q <= COOLING;
            div_q   <= '0;
            tr_q    <= 1'b0;
          end
        end
        COOLING: begin
          if (reactorheater) begin
            state_q <= HEATING;
            div_q   <= '0;
          end else if (div_q == DIV_W'(COOL_DIV - 1)) begin
            temp_q <= temp_q - W'(1);
            div_q  <= '0;
            if (temp_q <= W'(TEMP_AMBIENT + 1))
              state_q <= COLD;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          state_q <= COLD;
          div_q   <= '0;
          tr_q    <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- precursor warm-up ----------------
  logic [COUNT_W-1:0] warm_q;
  logic               tp1_q;

  // Dropping heaterson clears on any clk, not only on ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_q <= '0;
      tp1_q  <= 1'b0;
    end else if (!heaterson) begin
      warm_q <= '0;
      tp1_q  <= 1'b0;
    end else if (tick && (warm_q != COUNT_W'(P1_WARM_TICKS))) begin
      warm_q <= warm_q + COUNT_W'(1);
      tp1_q  <= (warm_q == COUNT_W'(P1_WARM_TICKS - 1));
    end
  end

  // ---------------- pulse counters ----------------
  ald_pulse_counter u_cnt_p1 (
    .clk     (clk),
    .rst     (rst),
    .valve_i (sv1),
    .count_o (pulses_p1)
  );

  ald_pulse_counter u_cnt_w (
    .clk     (clk),
    .rst     (rst),
    .valve_i (sv4),
    .count_o (pulses_w)
  );

  assign pressure        = pressure_q;
  assign pressure_switch = psw_q;
  assign atmosphere      = atm_q;
  assign fault           = fault_q;
  assign temp            = temp_q;
  assign tr              = tr_q;
  assign tp1             = tp1_q;
  assign temp_state_dbg  = state_q;

endmodule

// File: tb/tb_ald_chamber_sim.sv
// Self-checking bench for ald_chamber_sim: directed scenarios plus randomized commands
// compared against a tick-level arithmetic model of the chamber.
module tb_ald_chamber_sim;
  import ald_sim_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        vv1 = 1'b0, vv2 = 1'b0, sv1 = 1'b0, sv4 = 1'b0, mfc = 1'b0;
  logic        reactorheater = 1'b0, heaterson = 1'b0;
  logic [15:0] pressure, temp, pulses_p1, pulses_w;
  logic        pressure_switch, atmosphere, tr, tp1, fault;
  logic [1:0]  temp_state_dbg;

  int checks = 0;
  int failures = 0;

  ald_chamber_sim dut (
    .clk             (clk),
    .rst             (rst),
    .tick            (tick),
    .vv1             (vv1),
    .vv2             (vv2),
    .sv1             (sv1),
    .sv4             (sv4),
    .mfc             (mfc),
    .reactorheater   (reactorheater),
    .heaterson       (heaterson),
    .pressure        (pressure),
    .temp            (temp),
    .pressure_switch (pressure_switch),
    .atmosphere      (atmosphere),
    .tr              (tr),
    .tp1             (tp1),
    .fault           (fault),
    .pulses_p1       (pulses_p1),
    .pulses_w        (pulses_w),
    .temp_state_dbg  (temp_state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_COLD = 0, M_HEAT = 1, M_AT = 2, M_COOL = 3;

  int m_p, m_temp, m_mode, m_base, m_k, m_cnt, m_np1, m_nw;
  bit m_psw, m_atm, m_tp1, m_fault, prev_sv1, prev_sv4;

  task automatic model_reset();
    m_p = 1000; m_psw = 0; m_atm = 1;
    m_temp = 25; m_mode = M_COLD; m_base = 25; m_k = 0;
    m_cnt = 0; m_tp1 = 0; m_fault = 0;
    m_np1 = 0; m_nw = 0; prev_sv1 = 0; prev_sv4 = 0;
  endtask

  // Temperature in a ramping phase is the entry temperature plus/minus elapsed ticks / divider.
  task automatic model_enter(input int mode);
    m_mode = mode; m_base = m_temp; m_k = 0;
  endtask

  task automatic model_tick();
    int d, i_mfc, i_v1, i_v2, i_pulse, i_leak;
    i_mfc = mfc ? 1 : 0;
    i_v1 = vv1 ? 1 : 0;
    i_v2 = vv2 ? 1 : 0;
    i_pulse = (sv1 || sv4) ? 1 : 0;
    i_leak = (vv1 || vv2) ? 0 : 1;
    d = 8 * i_mfc + 2 * i_pulse + 1 * i_leak - 4 * (i_v1 + i_v2);
    m_p = m_p + d;
    if (m_p < 0) m_p = 0;
    if (m_p > 1000) m_p = 1000;
    m_psw = (m_p <= 100);
    m_atm = (m_p >= 950);
    if (sv1 && sv4) m_fault = 1;
    if (heaterson && m_cnt < 500) m_cnt++;
    m_tp1 = (m_cnt == 500);
    case (m_mode)
      M_COLD: if (reactorheater) model_enter(M_HEAT);
      M_HEAT: begin
        if (!reactorheater) model_enter(M_COOL);
        else begin
          m_k++;
          m_temp = m_base + m_k / 4;
          if (m_temp >= 200) model_enter(M_AT);
        end
      end
      M_AT: if (!reactorheater) model_enter(M_COOL);
      default: begin
        if (reactorheater) model_enter(M_HEAT);
        else begin
          m_k++;
          m_temp = m_base - m_k / 8;
          if (m_temp <= 25) model_enter(M_COLD);
        end
      end
    endcase
  endtask

  // ---------------- drivers ----------------
  task automatic set_cmd(input logic v1, input logic v2, input logic s1, input logic s4,
                         input logic m, input logic rh, input logic hs);
    vv1 = v1; vv2 = v2; sv1 = s1; sv4 = s4; mfc = m;
    reactorheater = rh; heaterson = hs;
    if (s1 && !prev_sv1 && m_np1 < 65535) m_np1++;
    if (s4 && !prev_sv4 && m_nw < 65535) m_nw++;
    prev_sv1 = s1; prev_sv4 = s4;
    if (!hs) begin
      m_cnt = 0; m_tp1 = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    tick = 0;
    rst = 0;
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  // Called at a negedge: one tick-high cycle then one idle cycle; returns at a negedge.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1;
      model_tick();
      @(negedge clk);
      tick = 0;
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (pressure !== 16'd1000 || atmosphere !== 1'b1 || pressure_switch !== 1'b0 ||
        temp !== 16'd25 || tr !== 1'b0 || tp1 !== 1'b0 || fault !== 1'b0 ||
        pulses_p1 !== 16'd0 || pulses_w !== 16'd0 || temp_state_dbg !== COLD) begin
      failures++;
      $display("FAIL reset_values: p=%0d atm=%b psw=%b t=%0d tr=%b tp1=%b f=%b n1=%0d nw=%0d st=%0d",
               pressure, atmosphere, pressure_switch, temp, tr, tp1, fault, pulses_p1, pulses_w,
               temp_state_dbg);
    end
    set_cmd(1, 0, 1, 1, 0, 1, 1);
    do_ticks(20);
    #2 rst = 0;
    #1;
    checks++;
    if (pressure !== 16'd1000 || temp !== 16'd25 || fault !== 1'b0 || pulses_p1 !== 16'd0 ||
        atmosphere !== 1'b1 || temp_state_dbg !== COLD) begin
      failures++;
      $display("FAIL async_reset: p=%0d t=%0d f=%b n1=%0d atm=%b st=%0d (want 1000 25 0 0 1 0)",
               pressure, temp, fault, pulses_p1, atmosphere, temp_state_dbg);
    end
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    set_cmd(1, 0, 0, 0, 0, 0, 0);
    do_ticks(1);
    checks++;
    if (pressure !== 16'd996) begin
      failures++;
      $display("FAIL first_tick_after_reset: pressure=%0d want 996", pressure);
    end
  endtask

  task automatic test_pump_single();
    apply_reset();
    set_cmd(1, 0, 0, 0, 0, 0, 0);
    do_ticks(12);
    checks++;
    if (pressure !== 16'd952 || atmosphere !== 1'b1) begin
      failures++;
      $display("FAIL pump1_tick12: p=%0d atm=%b want 952 1", pressure, atmosphere);
    end
    do_ticks(1);
    checks++;
    if (pressure !== 16'd948 || atmosphere !== 1'b0) begin
      failures++;
      $display("FAIL pump1_tick13: p=%0d atm=%b want 948 0", pressure, atmosphere);
    end
    do_ticks(211);
    checks++;
    if (pressure !== 16'd104 || pressure_switch !== 1'b0) begin
      failures++;
      $display("FAIL pump1_tick224: p=%0d psw=%b want 104 0", pressure, pressure_switch);
    end
    do_ticks(1);
    checks++;
    if (pressure !== 16'd100 || pressure_switch !== 1'b1) begin
      failures++;
      $display("FAIL pump1_tick225: p=%0d psw=%b want 100 1", pressure, pressure_switch);
    end
  endtask

  task automatic test_pump_dual();
    apply_reset();
    set_cmd(1, 1, 0, 0, 0, 0, 0);
    do_ticks(112);
    checks++;
    if (pressure !== 16'd104 || pressure_switch !== 1'b0) begin
      failures++;
      $display("FAIL pump2_tick112: p=%0d psw=%b want 104 0", pressure, pressure_switch);
    end
    do_ticks(1);
    checks++;
    if (pressure !== 16'd96 || pressure_switch !== 1'b1) begin
      failures++;
      $display("FAIL pump2_tick113: p=%0d psw=%b want 96 1", pressure, pressure_switch);
    end
    do_ticks(20);
    checks++;
    if (pressure !== 16'd0 || pressure_switch !== 1'b1) begin
      failures++;
      $display("FAIL pump2_floor: p=%0d psw=%b want 0 1", pressure, pressure_switch);
    end
  endtask

  task automatic test_fill();
    apply_reset();
    set_cmd(0, 0, 0, 0, 1, 0, 0);
    do_ticks(3);
    checks++;
    if (pressure !== 16'd1000 || atmosphere !== 1'b1) begin
      failures++;
      $display("FAIL fill_ceiling: p=%0d atm=%b want 1000 1", pressure, atmosphere);
    end
    set_cmd(1, 1, 0, 0, 0, 0, 0);
    do_ticks(130);
    // MFC alone with both vacuum valves shut also admits the leak: +9 per tick.
    set_cmd(0, 0, 0, 0, 1, 0, 0);
    do_ticks(1);
    checks++;
    if (pressure !== 16'd9) begin
      failures++;
      $display("FAIL fill_from_zero: p=%0d want 9", pressure);
    end
    do_ticks(104);
    checks++;
    if (pressure !== 16'd945 || atmosphere !== 1'b0) begin
      failures++;
      $display("FAIL fill_tick105: p=%0d atm=%b want 945 0", pressure, atmosphere);
    end
    do_ticks(1);
    checks++;
    if (pressure !== 16'd954 || atmosphere !== 1'b1) begin
      failures++;
      $display("FAIL fill_tick106: p=%0d atm=%b want 954 1", pressure, atmosphere);
    end
  endtask

  task automatic test_heater();
    apply_reset();
    set_cmd(0, 0, 0, 0, 0, 1, 0);
    do_ticks(700);
    checks++;
    if (temp !== 16'd199 || tr !== 1'b0 || temp_state_dbg !== HEATING) begin
      failures++;
      $display("FAIL heat_700: t=%0d tr=%b st=%0d want 199 0 1", temp, tr, temp_state_dbg);
    end
    do_ticks(1);
    checks++;
    if (temp !== 16'd200 || tr !== 1'b1 || temp_state_dbg !== AT_TEMP) begin
      failures++;
      $display("FAIL heat_701: t=%0d tr=%b st=%0d want 200 1 2", temp, tr, temp_state_dbg);
    end
    apply_reset();
    set_cmd(0, 0, 0, 0, 0, 1, 0);
    do_ticks(300);
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    do_ticks(1);
    checks++;
    if (temp !== 16'd99 || tr !== 1'b0 || temp_state_dbg !== COOLING) begin
      failures++;
      $display("FAIL cool_enter: t=%0d tr=%b st=%0d want 99 0 3", temp, tr, temp_state_dbg);
    end
    do_ticks(7);
    checks++;
    if (temp !== 16'd99) begin
      failures++;
      $display("FAIL cool_7: t=%0d want 99", temp);
    end
    do_ticks(1);
    checks++;
    if (temp !== 16'd98 || tr !== 1'b0) begin
      failures++;
      $display("FAIL cool_8: t=%0d tr=%b want 98 0", temp, tr);
    end
    do_ticks(600);
    checks++;
    if (temp !== 16'd25 || temp_state_dbg !== COLD) begin
      failures++;
      $display("FAIL cool_ambient: t=%0d st=%0d want 25 0", temp, temp_state_dbg);
    end
  endtask

  task automatic test_tp1();
    apply_reset();
    set_cmd(0, 0, 0, 0, 0, 0, 1);
    do_ticks(499);
    checks++;
    if (tp1 !== 1'b0) begin
      failures++;
      $display("FAIL tp1_499: tp1=%b want 0", tp1);
    end
    do_ticks(1);
    checks++;
    if (tp1 !== 1'b1) begin
      failures++;
      $display("FAIL tp1_500: tp1=%b want 1", tp1);
    end
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (tp1 !== 1'b0) begin
      failures++;
      $display("FAIL tp1_clear: tp1=%b want 0", tp1);
    end
    set_cmd(0, 0, 0, 0, 0, 0, 1);
    do_ticks(499);
    checks++;
    if (tp1 !== 1'b0) begin
      failures++;
      $display("FAIL tp1_restart: tp1=%b want 0", tp1);
    end
    do_ticks(1);
    checks++;
    if (tp1 !== 1'b1) begin
      failures++;
      $display("FAIL tp1_rewarm: tp1=%b want 1", tp1);
    end
  endtask

  task automatic test_pulses();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_cmd(0, 0, 1, 0, 0, 0, 0); do_ticks(1);
      set_cmd(0, 0, 0, 0, 0, 0, 0); do_ticks(1);
    end
    for (int i = 0; i < 2; i++) begin
      set_cmd(0, 0, 0, 1, 0, 0, 0); do_ticks(1);
      set_cmd(0, 0, 0, 0, 0, 0, 0); do_ticks(1);
    end
    checks++;
    if (pulses_p1 !== 16'd3 || pulses_w !== 16'd2 || fault !== 1'b0) begin
      failures++;
      $display("FAIL pulse_counts: n1=%0d nw=%0d f=%b want 3 2 0", pulses_p1, pulses_w, fault);
    end
    set_cmd(0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (fault !== 1'b0 || pulses_p1 !== 16'd4 || pulses_w !== 16'd3) begin
      failures++;
      $display("FAIL overlap_no_tick: f=%b n1=%0d nw=%0d want 0 4 3", fault, pulses_p1, pulses_w);
    end
    do_ticks(1);
    set_cmd(0, 0, 0, 0, 0, 0, 0);
    do_ticks(5);
    checks++;
    if (fault !== 1'b1) begin
      failures++;
      $display("FAIL fault_sticky: f=%b want 1", fault);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_reset: f=%b want 0", fault);
    end
    @(negedge clk);
    rst = 1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_random();
    logic v1, v2, s1, s4, m, rh, hs;
    int pat;
    apply_reset();
    v1 = 0; v2 = 0; s1 = 0; s4 = 0; m = 0; rh = 0; hs = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7, 0) == 0) begin
        v1 = 1'($urandom_range(1, 0));
        v2 = 1'($urandom_range(1, 0));
        m  = 1'($urandom_range(1, 0));
        pat = $urandom_range(19, 0);
        s1 = (pat < 4) || (pat == 19);
        s4 = (pat >= 4 && pat < 8) || (pat == 19);
      end
      if ($urandom_range(149, 0) == 0) rh = ~rh;
      if ($urandom_range(99, 0) == 0) hs = ~hs;
      set_cmd(v1, v2, s1, s4, m, rh, hs);
      do_ticks(1);
      checks++;
      if (pressure !== 16'(m_p) || pressure_switch !== m_psw || atmosphere !== m_atm ||
          temp !== 16'(m_temp) || tr !== (m_mode == M_AT) || tp1 !== m_tp1 ||
          fault !== m_fault || pulses_p1 !== 16'(m_np1) || pulses_w !== 16'(m_nw)) begin
        failures++;
        $display("FAIL random_tick%0d: dut p=%0d t=%0d psw=%b atm=%b tr=%b tp1=%b f=%b n1=%0d nw=%0d | model p=%0d t=%0d psw=%b atm=%b tr=%b tp1=%b f=%b n1=%0d nw=%0d",
                 i, pressure, temp, pressure_switch, atmosphere, tr, tp1, fault, pulses_p1,
                 pulses_w, m_p, m_temp, m_psw, m_atm, (m_mode == M_AT), m_tp1, m_fault, m_np1,
                 m_nw);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_pump_single();
    test_pump_dual();
    test_fill();
    test_heater();
    test_tp1();
    test_pulses();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
